// File: rtl/uart_word_echo_if.sv
// UART byte-side bundle for uart_word_echo: rx strobe/data, tx handshake,
// transform mode select and status outputs. master = echo engine, slave = environment.
interface uart_word_echo_if #(
   parameter int WORD_BYTES = 2,
   parameter int DEPTH      = 4
);
   logic                     rx_available;
   logic [7:0]               rx_data;
   logic                     tx_ready;
   logic [1:0]               mode;
   logic                     start_tx;
   logic [7:0]               tx_data;
   logic                     status_led;
   logic                     overflow;
   logic [$clog2(DEPTH):0]   words_stored;

   modport master (
      input  rx_available, rx_data, tx_ready, mode,
      output start_tx, tx_data, status_led, overflow, words_stored
   );

   modport slave (
      output rx_available, rx_data, tx_ready, mode,
      input  start_tx, tx_data, status_led, overflow, words_stored
   );
endinterface

// File: rtl/uart_word_echo.sv
// UART word echo engine: packs rx bytes into words, buffers them in a FIFO and
// sends them back (optionally transformed) after a one-shot banner word.
// Ports: clk, reset (async, active-high), uart_io (uart_word_echo_if.master).
module uart_word_echo #(
   parameter int          WORD_BYTES = 2,
   parameter int          DEPTH      = 4,
   parameter int          TIMEOUT    = 100000,
   parameter logic [31:0] BANNER     = 32'h1234
) (
   input  logic             clk,
   input  logic             reset,
   uart_word_echo_if.master uart_io
);
   localparam int W  = 8 * WORD_BYTES;
   localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [BW-1:0] LAST    = BW'(WORD_BYTES - 1);
   localparam logic [TW-1:0] TLAST   = TW'(TIMEOUT - 1);
   localparam logic [AW:0]   FULL    = (AW + 1)'(DEPTH);
   localparam logic [W-1:0]  BANNERW = W'(BANNER);

   typedef enum logic [2:0] {
      BANNER_LOAD,
      IDLE,
      LOAD,
      SEND,
      WAIT
   } state_t;

   function automatic logic [W-1:0] xform(input logic [W-1:0] w,
                                          input logic [1:0]   m);
      logic [W-1:0] r;
      r = w;
      case (m)
         2'd1: r = w + 1'b1;
         2'd2: for (int i = 0; i < WORD_BYTES; i++)
                  r[8*i +: 8] = w[8*(WORD_BYTES-1-i) +: 8];
         2'd3: r = ~w;
         default: r = w;
      endcase
      return r;
   endfunction

   // rx assembly
   logic [BW-1:0] bcnt_q;
   logic [TW-1:0] timer_q;
   logic [W-1:0]  asm_q, asm_d;
   logic [W-1:0]  push_word_q;
   logic          push_q;
   logic          led_q;

   // fifo
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   cnt_q;
   logic          ovf_q;
   logic          pop;
   logic          push_ok;

   // tx
   state_t        state_q;
   logic [W-1:0]  shreg_q;
   logic [BW-1:0] k_q;
   logic          start_q;
   logic [7:0]    txd_q;

   always_comb begin
      asm_d = asm_q;
      asm_d[8*bcnt_q +: 8] = uart_io.rx_data;
   end

   // Completed word is registered and pushed one cycle later; bcnt is
   // already back at 0, so a byte arriving on the push cycle starts a new word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bcnt_q      <= '0;
         timer_q     <= '0;
         asm_q       <= '0;
         push_word_q <= '0;
         push_q      <= 1'b0;
         led_q       <= 1'b0;
      end else begin
         push_q <= 1'b0;
         if (uart_io.rx_available) begin
            timer_q <= '0;
            if (bcnt_q == LAST) begin
               bcnt_q      <= '0;
               asm_q       <= '0;
               push_word_q <= asm_d;
               push_q      <= 1'b1;
               led_q       <= 1'b1;
            end else begin
               bcnt_q <= bcnt_q + 1'b1;
               asm_q  <= asm_d;
            end
         end else if (bcnt_q != '0) begin
            if (timer_q == TLAST) begin
               bcnt_q  <= '0;
               timer_q <= '0;
               asm_q   <= '0;
            end else begin
               timer_q <= timer_q + 1'b1;
            end
         end
      end
   end

   // Only LOAD pops; it is entered only with a non-empty FIFO.
   assign pop     = (state_q == LOAD);
   assign push_ok = push_q && ((cnt_q != FULL) || pop);

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= push_word_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + 1'b1;
         if (pop)     rptr_q <= rptr_q + 1'b1;
         if (push_q && !push_ok) ovf_q <= 1'b1;
         case ({push_ok, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= BANNER_LOAD;
         shreg_q <= '0;
         k_q     <= '0;
         start_q <= 1'b0;
         txd_q   <= '0;
      end else begin
         start_q <= 1'b0;
         case (state_q)
            BANNER_LOAD: begin
               shreg_q <= BANNERW;
               k_q     <= '0;
               state_q <= SEND;
            end
            IDLE: begin
               if (cnt_q != '0) state_q <= LOAD;
            end
            LOAD: begin
               shreg_q <= xform(mem_q[rptr_q], uart_io.mode);
               k_q     <= '0;
               state_q <= SEND;
            end
            SEND: begin
               if (uart_io.tx_ready) begin
                  start_q <= 1'b1;
                  txd_q   <= shreg_q[8*k_q +: 8];
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (!uart_io.tx_ready) begin
                  k_q     <= k_q + 1'b1;
                  state_q <= (k_q == LAST) ? IDLE : SEND;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign uart_io.start_tx     = start_q;
   assign uart_io.tx_data      = txd_q;
   assign uart_io.status_led   = led_q;
   assign uart_io.overflow     = ovf_q;
   assign uart_io.words_stored = cnt_q;
endmodule
